// File: rtl/div_recon_mul.sv
// Sequential shift-add multiplier rebuilding a dividend: x = q*y + r, one multiplier bit per cycle.
// Optional macro DIV_RECON_EARLY_EXIT_EN ends BUSY once the remaining multiplier bits are all zero.

module div_recon_cell #(
  parameter bit APPROX = 1'b0
) (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  // Approximate cell passes the accumulator bit through and forwards the addend bit as carry,
  // cutting the carry chain at the cost of accuracy.
  assign s  = APPROX ? a : (a ^ b ^ ci);
  assign co = APPROX ? b : ((a & b) | (a & ci) | (b & ci));
endmodule

module div_recon_mul #(
  parameter int W           = 8,
  parameter int APPROX_COLS = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   q,
  input  logic [W-1:0]   y,
  input  logic [W-1:0]   r,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] x
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_nx;
  logic [2*W-1:0] acc, md, addend, sum;
  logic [2*W:0]   c;
  logic [W-1:0]   mq;
  logic [CW-1:0]  cnt;
  logic           last_step;
  logic           unused_carry;

  assign addend = mq[0] ? (md << cnt) : '0;
  assign c[0]   = 1'b0;

  genvar j;
  generate
    for (j = 0; j < 2*W; j++) begin : g_col
      div_recon_cell #(.APPROX(j < APPROX_COLS)) u_cell (
        .a  (acc[j]),
        .b  (addend[j]),
        .ci (c[j]),
        .s  (sum[j]),
        .co (c[j+1])
      );
    end
  endgenerate

  // Carry out of the top column is dropped; low carries are dead in approximate columns.
  assign unused_carry = ^c;

`ifdef DIV_RECON_EARLY_EXIT_EN
  assign last_step = (cnt == CW'(W-1)) || ((mq >> 1) == '0);
`else
  assign last_step = (cnt == CW'(W-1));
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = BUSY;
      BUSY:    if (last_step) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      md    <= '0;
      mq    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          acc <= {{W{1'b0}}, r};
          md  <= {{W{1'b0}}, y};
          mq  <= q;
          cnt <= '0;
        end
        BUSY: begin
          acc <= sum;
          mq  <= mq >> 1;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // acc only moves in BUSY, so it is stable for the whole DONE window.
  assign x         = acc;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
endmodule

// File: tb/tb_div_recon_mul.sv
// Directed bench for div_recon_mul: exact and APPROX_COLS=4 instances share one stimulus stream.
module tb_div_recon_mul;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  q = '0, y = '0, r = '0;
  logic        in_ready, out_valid, in_ready_a, out_valid_a;
  logic [15:0] x, x_a;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  div_recon_mul #(.W(8), .APPROX_COLS(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .y(y), .r(r), .out_valid(out_valid), .out_ready(out_ready), .x(x)
  );

  div_recon_mul #(.W(8), .APPROX_COLS(4)) u_apx (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .q(q), .y(y), .r(r), .out_valid(out_valid_a), .out_ready(out_ready), .x(x_a)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic int exp_lat(input logic [7:0] qq);
`ifdef DIV_RECON_EARLY_EXIT_EN
    int m = 0;
    for (int i = 0; i < 8; i++) if (qq[i]) m = i;
    return m + 1;
`else
    return 8;
`endif
  endfunction

  // Called #1 after a rising edge. lat = edges after the accepting edge until out_valid.
  task automatic do_op(input logic [7:0] qq, yy, rr, input int hold,
                       output logic [15:0] xo, output int lat);
    int k = 0;
    while (!in_ready && k < 100) begin @(posedge clk); #1; k++; end
    in_valid = 1'b1; q = qq; y = yy; r = rr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    xo = x;
    for (int h = 0; h < hold; h++) begin
      chk("bp_x_stable", {16'h0, x}, {16'h0, xo});
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
      chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [15:0] xr, exp_x;
  int          lat;
  logic [7:0]  rq, ry, rr;

  initial begin
    #12;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_x", {16'h0, x}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Maximum operands
    do_op(8'hFF, 8'hFF, 8'hFF, 0, xr, lat);
    chk("max_x", {16'h0, xr}, 32'hFF00);
    chk("max_lat", lat, exp_lat(8'hFF));
    chk("max_consumed_valid", {31'h0, out_valid}, 32'h0);
    chk("max_consumed_ready", {31'h0, in_ready}, 32'h1);

    // Zero quotient
    do_op(8'h00, 8'h37, 8'h2A, 0, xr, lat);
    chk("zero_x", {16'h0, xr}, 32'h002A);
    chk("zero_lat", lat, exp_lat(8'h00));

    // Approximate columns: both instances see the same operands
    do_op(8'h01, 8'h0F, 8'h01, 0, xr, lat);
    chk("apx0_x", {16'h0, xr}, 32'h0010);
    chk("apx4_x", {16'h0, x_a}, 32'h0011);

    // Backpressure for 6 cycles
    do_op(8'h12, 8'h34, 8'h05, 6, xr, lat);
    chk("bp_x", {16'h0, xr}, 32'h03AD);
    chk("bp_after_valid", {31'h0, out_valid}, 32'h0);
    chk("bp_after_ready", {31'h0, in_ready}, 32'h1);

    // Async reset in cycle N+4 of an operation
    in_valid = 1'b1; q = 8'hA5; y = 8'h77; r = 8'h10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_x", {16'h0, x}, 32'h0);
    chk("arst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(8'h03, 8'h03, 8'h00, 0, xr, lat);
    chk("arst_next_x", {16'h0, xr}, 32'h0009);
    chk("arst_next_lat", lat, exp_lat(8'h03));

    // Random sweep with round trip through a divide model
    for (int n = 0; n < 2000; n++) begin
      rq = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(1, 255));
      rr = 8'($urandom_range(0, int'(ry) - 1));
      exp_x = 16'(rq) * 16'(ry) + 16'(rr);
      do_op(rq, ry, rr, 0, xr, lat);
      chk("rand_x", {16'h0, xr}, {16'h0, exp_x});
      chk("rand_div_q", {16'h0, xr / 16'(ry)}, {24'h0, rq});
      chk("rand_div_r", {16'h0, xr % 16'(ry)}, {24'h0, rr});
      if (n < 50) chk("rand_lat", lat, exp_lat(rq));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
